ila_refcheck_window: RTL and testbench
======================================

Name: ila_refcheck_window

Overview:
- Parametrised instruction-window monitor for ILA-vs-RTL refinement checks on multi-channel link blocks.
- Successor to the single-channel hand-written wrapper logic: one generic block provides the following for NUM_CH channels, with configurable window lengths:
  - start/started/ended sequencing;
  - a saturating cycle counter;
  - first- and second-end pulses;
  - per-channel token-edge and valid-pulse shaping;
  - reset-loaded commit snapshots;
  - a sticky pass/fail verdict.
- Sits beside the ILA model and the RTL under test; its outputs drive assumptions and assertions.

Parameters:
NUM_CH, 2, number of monitored channels (>=1)
CNT_W, 4, cycle counter width
MAX_CYCLE, 7, counter saturation value (< 2**CNT_W)
END_CYCLE, 2, counter value that ends the instruction window (<= MAX_CYCLE)
END2_CYCLE, 2, counter value qualifying the second end (<= MAX_CYCLE)
ST_W, 7, width of each per-channel commit snapshot

Ports:
clk  in  1  single clock; all state updates on posedge
rst  in  1  synchronous active-high reset
issue_i  in  1  request to open an instruction window
match_i  in  NUM_CH  per-channel refinement-map equality bits
tok_i  in  NUM_CH  per-channel token level from RTL
vld_i  in  NUM_CH  per-channel raw valid from RTL
commit_init_i  in  NUM_CH*ST_W  snapshot init values, channel c at [c*ST_W +: ST_W]
start_o  out  1  one-cycle window start (ILA read enable)
started_o  out  1  sticky: window running
ended_o  out  1  sticky: first end reached
ended2_o  out  1  sticky: second end reached
iend_o  out  1  combinational first-end pulse
iend2_o  out  1  combinational second-end pulse
reseted_o  out  1  sticky: a reset has been seen
cycle_cnt_o  out  CNT_W  window cycle counter
tok_evt_o  out  NUM_CH  token toggle events
vld_pulse_o  out  NUM_CH  shaped valid pulses
commit_o  out  NUM_CH*ST_W  held commit snapshots
fail_o  out  1  sticky: mismatch at first end
fail_vec_o  out  NUM_CH  match_i captured at first failing end

Behaviour:
- Reset values (rst high at a posedge): all registered outputs 0, state IDLE, except:
  - reseted_o = 1, sticky forever;
  - commit_o loaded from commit_init_i.
- Power-up value of reseted_o is 0.
- FSM, one transition per clock:
  - IDLE --issue_i--> START: start_o = 1 for exactly 1 cycle.
  - START --> RUN: started_o = 1.
  - RUN --iend_o--> ENDED: ended_o = 1.
  - ENDED --iend2_o--> DONE: ended2_o = 1.
  - issue_i outside IDLE is ignored. rst wins over issue_i in the same cycle.
- cycle_cnt_o:
  - increments by 1 each cycle while start_o or started_o is high;
  - saturates at MAX_CYCLE, never wraps.
- iend_o = (cycle_cnt_o == END_CYCLE) & started_o & reseted_o & ~ended_o.
- iend2_o = ended_o & (cycle_cnt_o == END2_CYCLE) & started_o & ~ended2_o.
  - If END2_CYCLE == END_CYCLE, iend2_o fires the cycle after iend_o only if the counter is still equal, i.e. only when saturated at MAX_CYCLE; otherwise ended2_o never sets.
- Verdict:
  - On iend_o with ~&match_i: fail_o <= 1 and fail_vec_o <= match_i.
  - Later cycles never change either output until the next reset.
- Token events: tok_q[c] <= tok_i[c] each cycle (reset 0); tok_evt_o = tok_i ^ tok_q, combinational.
- Valid shaping: vld_pulse_o[c] <= vld_i[c] & ~vld_pulse_o[c].
  - A held valid therefore yields a 1,0,1,0... pattern.
- Commit snapshots hold their value outside reset.

Optional Feature:
- Macro REFCHK_REARM_EN.
- Defined:
  - issue_i in DONE returns the FSM to START;
  - cycle_cnt_o, started_o, ended_o and ended2_o clear in that same cycle;
  - commit_o reloads from commit_init_i;
  - fail_o and fail_vec_o are retained (sticky across windows).
- Undefined: DONE is terminal until rst, and issue_i in DONE is ignored.

Test Plan:
- rst 1 cycle, issue_i at cycle 3 -> start_o high cycle 4 only, started_o from cycle 5; cycle_cnt_o 1,2,3,...; iend_o high when cycle_cnt_o==2; ended_o 1 next cycle.
- Window left open 10 cycles -> cycle_cnt_o saturates at 7, never reaches 0.
- NUM_CH=2, match_i=2'b10 at iend_o -> fail_o=1, fail_vec_o=2'b10; later match_i=2'b11 leaves both unchanged.
- tok_i[0] sequence 0,1,1,0 -> tok_evt_o[0] 0,1,0,1; vld_i[1] held high 4 cycles -> vld_pulse_o[1] 1,0,1,0.
- commit_init_i=0x2A for ch0 during rst, changed afterwards -> commit_o ch0 stays 0x2A; issue_i and rst together -> state IDLE, start_o 0.
- With REFCHK_REARM_EN: reach DONE, pulse issue_i -> start_o 1, cycle_cnt_o 0, ended_o 0, second window ends at count 2 again; without the macro -> no start_o.

Source files
------------

// File: rtl/ila_refcheck_window.sv
// ila_refcheck_window: instruction-window monitor for ILA-vs-RTL refinement checks.
// Handles start/started/ended sequencing, a saturating cycle counter, first and
// second end pulses, per-channel token-edge and valid-pulse shaping, commit
// snapshots loaded at reset, and a sticky pass/fail verdict.
// Optional feature: define REFCHK_REARM_EN so that issue_i in DONE re-arms the window.
module ila_refcheck_window #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned MAX_CYCLE  = 7,
  parameter int unsigned END_CYCLE  = 2,
  parameter int unsigned END2_CYCLE = 2,
  parameter int unsigned ST_W       = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_i,
  input  logic [NUM_CH-1:0]        match_i,
  input  logic [NUM_CH-1:0]        tok_i,
  input  logic [NUM_CH-1:0]        vld_i,
  input  logic [NUM_CH*ST_W-1:0]   commit_init_i,
  output logic                     start_o,
  output logic                     started_o,
  output logic                     ended_o,
  output logic                     ended2_o,
  output logic                     iend_o,
  output logic                     iend2_o,
  output logic                     reseted_o,
  output logic [CNT_W-1:0]         cycle_cnt_o,
  output logic [NUM_CH-1:0]        tok_evt_o,
  output logic [NUM_CH-1:0]        vld_pulse_o,
  output logic [NUM_CH*ST_W-1:0]   commit_o,
  output logic                     fail_o,
  output logic [NUM_CH-1:0]        fail_vec_o
);

  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_CYCLE);
  localparam logic [CNT_W-1:0] END_C  = CNT_W'(END_CYCLE);
  localparam logic [CNT_W-1:0] END2_C = CNT_W'(END2_CYCLE);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RUN   = 3'd2,
    ENDED = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               rearm_c;
  logic [NUM_CH-1:0]  tok_q;

  // reseted_o must read 0 before the first reset is ever applied.
  logic               reseted_q = 1'b0;

  assign reseted_o = reseted_q;

  // End pulses and token edges are combinational views of registered state.
  assign iend_o    = (cycle_cnt_o == END_C) & started_o & reseted_q & ~ended_o;
  assign iend2_o   = ended_o & (cycle_cnt_o == END2_C) & started_o & ~ended2_o;
  assign tok_evt_o = tok_i ^ tok_q;

  // Next-state logic for the window sequencer.
  always_comb begin
    state_d = state_q;
    rearm_c = 1'b0;
    case (state_q)
      IDLE:    if (issue_i) state_d = START;
      START:   state_d = RUN;
      RUN:     if (iend_o) state_d = ENDED;
      ENDED:   if (iend2_o) state_d = DONE;
      DONE: begin
`ifdef REFCHK_REARM_EN
        if (issue_i) begin
          state_d = START;
          rearm_c = 1'b1;
        end
`else
        state_d = DONE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and registered window flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      start_o   <= 1'b0;
      started_o <= 1'b0;
      ended_o   <= 1'b0;
      ended2_o  <= 1'b0;
      reseted_q <= 1'b1;
    end else begin
      state_q <= state_d;
      start_o <= (state_d == START);
      if (rearm_c) begin
        started_o <= 1'b0;
        ended_o   <= 1'b0;
        ended2_o  <= 1'b0;
      end else begin
        if (state_q == START) started_o <= 1'b1;
        if (iend_o)           ended_o   <= 1'b1;
        if (iend2_o)          ended2_o  <= 1'b1;
      end
    end
  end

  // Window cycle counter, saturating at MAX_CYCLE.
  always_ff @(posedge clk) begin
    if (rst || rearm_c) begin
      cycle_cnt_o <= '0;
    end else if ((start_o || started_o) && (cycle_cnt_o != MAX_C)) begin
      cycle_cnt_o <= cycle_cnt_o + CNT_W'(1);
    end
  end

  // Sticky verdict: only the first failing end is recorded.
  always_ff @(posedge clk) begin
    if (rst) begin
      fail_o     <= 1'b0;
      fail_vec_o <= '0;
    end else if (iend_o && !(&match_i) && !fail_o) begin
      fail_o     <= 1'b1;
      fail_vec_o <= match_i;
    end
  end

  // Per-channel token history and valid pulse shaping.
  always_ff @(posedge clk) begin
    if (rst) begin
      tok_q       <= '0;
      vld_pulse_o <= '0;
    end else begin
      tok_q       <= tok_i;
      vld_pulse_o <= vld_i & ~vld_pulse_o;
    end
  end

  // Commit snapshots: loaded at reset (and on re-arm), held otherwise.
  always_ff @(posedge clk) begin
    if (rst || rearm_c) begin
      commit_o <= commit_init_i;
    end
  end

endmodule

// File: tb/tb_ila_refcheck_window.sv
// Directed testbench for ila_refcheck_window. Instance u_dut uses END2_CYCLE=4 so
// DONE is reachable; u_dflt keeps END2_CYCLE==END_CYCLE where ended2_o never sets.
module tb_ila_refcheck_window;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ST_W   = 7;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    issue_i;
  logic [NUM_CH-1:0]       match_i;
  logic [NUM_CH-1:0]       tok_i;
  logic [NUM_CH-1:0]       vld_i;
  logic [NUM_CH*ST_W-1:0]  commit_init_i;

  logic                    start_o, started_o, ended_o, ended2_o, iend_o, iend2_o, reseted_o, fail_o;
  logic [CNT_W-1:0]        cycle_cnt_o;
  logic [NUM_CH-1:0]       tok_evt_o, vld_pulse_o, fail_vec_o;
  logic [NUM_CH*ST_W-1:0]  commit_o;

  logic                    d_start, d_started, d_ended, d_ended2, d_iend, d_iend2, d_reseted, d_fail;
  logic [CNT_W-1:0]        d_cnt;
  logic [NUM_CH-1:0]       d_tok_evt, d_vld_pulse, d_fail_vec;
  logic [NUM_CH*ST_W-1:0]  d_commit;

  int total = 0;
  int bad   = 0;

  ila_refcheck_window #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .MAX_CYCLE(7), .END_CYCLE(2), .END2_CYCLE(4), .ST_W(ST_W)
  ) u_dut (
    .clk(clk), .rst(rst), .issue_i(issue_i), .match_i(match_i), .tok_i(tok_i), .vld_i(vld_i),
    .commit_init_i(commit_init_i), .start_o(start_o), .started_o(started_o), .ended_o(ended_o),
    .ended2_o(ended2_o), .iend_o(iend_o), .iend2_o(iend2_o), .reseted_o(reseted_o),
    .cycle_cnt_o(cycle_cnt_o), .tok_evt_o(tok_evt_o), .vld_pulse_o(vld_pulse_o),
    .commit_o(commit_o), .fail_o(fail_o), .fail_vec_o(fail_vec_o)
  );

  ila_refcheck_window u_dflt (
    .clk(clk), .rst(rst), .issue_i(issue_i), .match_i(match_i), .tok_i(tok_i), .vld_i(vld_i),
    .commit_init_i(commit_init_i), .start_o(d_start), .started_o(d_started), .ended_o(d_ended),
    .ended2_o(d_ended2), .iend_o(d_iend), .iend2_o(d_iend2), .reseted_o(d_reseted),
    .cycle_cnt_o(d_cnt), .tok_evt_o(d_tok_evt), .vld_pulse_o(d_vld_pulse),
    .commit_o(d_commit), .fail_o(d_fail), .fail_vec_o(d_fail_vec)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_powerup();
    #1;
    total++; if (reseted_o !== 1'b0) begin bad++; $display("FAIL powerup_reseted got=%b exp=0", reseted_o); end
  endtask

  task automatic test_reset();
    rst = 1'b1; issue_i = 1'b0; match_i = '0; tok_i = '0; vld_i = '0;
    commit_init_i = {7'h15, 7'h2A};
    tick();
    rst = 1'b0;
    total++; if (reseted_o !== 1'b1) begin bad++; $display("FAIL rst_reseted got=%b exp=1", reseted_o); end
    total++; if ({start_o, started_o, ended_o, ended2_o, fail_o} !== 5'b0) begin bad++; $display("FAIL rst_flags got=%b exp=00000", {start_o, started_o, ended_o, ended2_o, fail_o}); end
    total++; if (cycle_cnt_o !== 4'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", cycle_cnt_o); end
    total++; if (commit_o !== {7'h15, 7'h2A}) begin bad++; $display("FAIL rst_commit got=%h exp=%h", commit_o, {7'h15, 7'h2A}); end
    commit_init_i = {7'h7F, 7'h00};
    tick();
    tick();
    total++; if (commit_o[6:0] !== 7'h2A) begin bad++; $display("FAIL commit_hold got=%h exp=2a", commit_o[6:0]); end
    total++; if (start_o !== 1'b0) begin bad++; $display("FAIL idle_start got=%b exp=0", start_o); end
  endtask

  task automatic test_window();
    issue_i = 1'b1; match_i = 2'b10;
    tick();
    issue_i = 1'b0;
    total++; if ({start_o, started_o} !== 2'b10) begin bad++; $display("FAIL win_start got=%b exp=10", {start_o, started_o}); end
    total++; if (cycle_cnt_o !== 4'd0) begin bad++; $display("FAIL win_cnt0 got=%0d exp=0", cycle_cnt_o); end
    tick();
    total++; if ({start_o, started_o} !== 2'b01) begin bad++; $display("FAIL win_started got=%b exp=01", {start_o, started_o}); end
    total++; if ({cycle_cnt_o, iend_o} !== {4'd1, 1'b0}) begin bad++; $display("FAIL win_cnt1 got=%0d/%b exp=1/0", cycle_cnt_o, iend_o); end
    tick();
    total++; if ({cycle_cnt_o, iend_o, d_iend} !== {4'd2, 1'b1, 1'b1}) begin bad++; $display("FAIL win_iend got=%0d/%b/%b exp=2/1/1", cycle_cnt_o, iend_o, d_iend); end
    tick();
    total++; if ({ended_o, fail_o, fail_vec_o} !== 4'b1110) begin bad++; $display("FAIL win_fail got=%b exp=1110", {ended_o, fail_o, fail_vec_o}); end
    total++; if ({cycle_cnt_o, iend_o} !== {4'd3, 1'b0}) begin bad++; $display("FAIL win_cnt3 got=%0d/%b exp=3/0", cycle_cnt_o, iend_o); end
    match_i = 2'b11; issue_i = 1'b1;
    tick();
    issue_i = 1'b0;
    total++; if (start_o !== 1'b0) begin bad++; $display("FAIL issue_ignored got=%b exp=0", start_o); end
    total++; if ({cycle_cnt_o, iend2_o} !== {4'd4, 1'b1}) begin bad++; $display("FAIL win_iend2 got=%0d/%b exp=4/1", cycle_cnt_o, iend2_o); end
    tick();
    total++; if ({ended2_o, cycle_cnt_o} !== {1'b1, 4'd5}) begin bad++; $display("FAIL win_ended2 got=%b/%0d exp=1/5", ended2_o, cycle_cnt_o); end
    repeat (6) tick();
    total++; if (cycle_cnt_o !== 4'd7) begin bad++; $display("FAIL cnt_sat got=%0d exp=7", cycle_cnt_o); end
    total++; if ({fail_o, fail_vec_o} !== 3'b110) begin bad++; $display("FAIL fail_sticky got=%b exp=110", {fail_o, fail_vec_o}); end
    total++; if ({d_ended, d_ended2, d_cnt} !== {1'b1, 1'b0, 4'd7}) begin bad++; $display("FAIL dflt_end2 got=%b/%b/%0d exp=1/0/7", d_ended, d_ended2, d_cnt); end
  endtask

  task automatic test_rearm();
    commit_init_i = {7'h33, 7'h44};
    issue_i = 1'b1;
    tick();
    issue_i = 1'b0;
    total++; if (d_start !== 1'b0) begin bad++; $display("FAIL dflt_no_rearm got=%b exp=0", d_start); end
`ifdef REFCHK_REARM_EN
    total++; if ({start_o, started_o, ended_o, ended2_o} !== 4'b1000) begin bad++; $display("FAIL rearm_flags got=%b exp=1000", {start_o, started_o, ended_o, ended2_o}); end
    total++; if (cycle_cnt_o !== 4'd0) begin bad++; $display("FAIL rearm_cnt got=%0d exp=0", cycle_cnt_o); end
    total++; if (commit_o !== {7'h33, 7'h44}) begin bad++; $display("FAIL rearm_commit got=%h exp=%h", commit_o, {7'h33, 7'h44}); end
    total++; if ({fail_o, fail_vec_o} !== 3'b110) begin bad++; $display("FAIL rearm_fail got=%b exp=110", {fail_o, fail_vec_o}); end
    tick();
    tick();
    total++; if ({cycle_cnt_o, iend_o} !== {4'd2, 1'b1}) begin bad++; $display("FAIL rearm_iend got=%0d/%b exp=2/1", cycle_cnt_o, iend_o); end
`else
    total++; if ({start_o, ended2_o, cycle_cnt_o} !== {1'b0, 1'b1, 4'd7}) begin bad++; $display("FAIL done_terminal got=%b/%b/%0d exp=0/1/7", start_o, ended2_o, cycle_cnt_o); end
    total++; if (commit_o !== {7'h15, 7'h2A}) begin bad++; $display("FAIL done_commit got=%h exp=%h", commit_o, {7'h15, 7'h2A}); end
`endif
  endtask

  task automatic test_tok_vld();
    logic [3:0] tok_seq;
    logic [3:0] evt_exp;
    logic [3:0] vld_exp;
    tok_seq = 4'b0110;  // applied MSB first: 0,1,1,0
    evt_exp = 4'b0101;  // expected 0,1,0,1
    vld_exp = 4'b1010;  // expected 1,0,1,0
    for (int i = 3; i >= 0; i--) begin
      tok_i[0] = tok_seq[i];
      #1;
      total++; if (tok_evt_o[0] !== evt_exp[i]) begin bad++; $display("FAIL tok_evt step=%0d got=%b exp=%b", 3 - i, tok_evt_o[0], evt_exp[i]); end
      tick();
    end
    vld_i = 2'b10;
    for (int i = 3; i >= 0; i--) begin
      tick();
      total++; if (vld_pulse_o[1] !== vld_exp[i]) begin bad++; $display("FAIL vld_pulse step=%0d got=%b exp=%b", 3 - i, vld_pulse_o[1], vld_exp[i]); end
    end
    vld_i = 2'b00;
    tick();
  endtask

  task automatic test_rst_issue();
    rst = 1'b1; issue_i = 1'b1; commit_init_i = {7'h01, 7'h2A};
    tick();
    rst = 1'b0; issue_i = 1'b0; commit_init_i = {7'h55, 7'h55};
    total++; if ({start_o, started_o, ended_o, fail_o, fail_vec_o} !== 6'b0) begin bad++; $display("FAIL rst_issue got=%b exp=000000", {start_o, started_o, ended_o, fail_o, fail_vec_o}); end
    tick();
    total++; if (start_o !== 1'b0) begin bad++; $display("FAIL rst_issue_idle got=%b exp=0", start_o); end
    total++; if (commit_o[6:0] !== 7'h2A) begin bad++; $display("FAIL commit_rst2 got=%h exp=2a", commit_o[6:0]); end
    match_i = 2'b11; issue_i = 1'b1;
    tick();
    issue_i = 1'b0;
    repeat (3) tick();
    total++; if ({ended_o, fail_o} !== 2'b10) begin bad++; $display("FAIL pass_window got=%b exp=10", {ended_o, fail_o}); end
  endtask

  initial begin
    rst = 1'b1; issue_i = 1'b0; match_i = '0; tok_i = '0; vld_i = '0; commit_init_i = '0;
    test_powerup();
    test_reset();
    test_window();
    test_rearm();
    test_tok_vld();
    test_rst_issue();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
